messbauer_reset_sequencer: RTL and testbench



---
 rtl/messbauer_reset_sequencer_pkg.sv | 21 ++
 rtl/messbauer_reset_sequencer_if.sv | 14 +
 rtl/messbauer_reset_sequencer_release_shifter.sv | 34 +++
 rtl/messbauer_reset_sequencer.sv | 129 ++++++++++++
 tb/tb_messbauer_reset_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/messbauer_reset_sequencer_pkg.sv
// Shared types and timing defaults for the Mossbauer channel reset sequencer.
// The environment top level also reuses the default delay/width constants.
package messbauer_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

  localparam int DEFAULT_PRE_DELAY   = 16;
  localparam int DEFAULT_PULSE_WIDTH = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/messbauer_reset_sequencer_if.sv
// Request/status bundle between the environment top level and the reset sequencer.
interface messbauer_reset_sequencer_if #(
  parameter int CHANNEL_COUNT = 2
);

  logic                     request;
  logic [CHANNEL_COUNT-1:0] channel_reset_n;
  logic                     busy;
  logic                     done;

  modport master (output request, input channel_reset_n, busy, done);
  modport slave  (input request, output channel_reset_n, busy, done);

endinterface

// File: rtl/messbauer_reset_sequencer_release_shifter.sv
// Per-channel release mask: cleared on assertion, then fills with ones from bit 0
// upward, one bit per step, or all at once when there is no stagger.
module messbauer_reset_sequencer_release_shifter #(
  parameter int CHANNEL_COUNT = 2,
  parameter int STAGGER       = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_start,
  input  logic                     i_step,
  output logic [CHANNEL_COUNT-1:0] o_mask
);

  localparam logic [CHANNEL_COUNT-1:0] ONE = CHANNEL_COUNT'(1);
  localparam logic [CHANNEL_COUNT-1:0] ALL = '1;

  logic [CHANNEL_COUNT-1:0] r_mask;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask <= ALL;
    end else if (i_clear) begin
      r_mask <= '0;
    end else if (i_start) begin
      r_mask <= (STAGGER == 0) ? ALL : ONE;
    end else if (i_step) begin
      r_mask <= (r_mask << 1) | ONE;
    end
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/messbauer_reset_sequencer.sv
// Channel reset sequencer: wait, hold all channels in reset, then release them
// in staggered order; re-runnable by request once done.
//   state      | meaning
//   ST_WAIT    | all channels out of reset, counting PRE_DELAY
//   ST_ASSERT  | all channels in reset, counting PULSE_WIDTH
//   ST_RELEASE | releasing channels one per STAGGER cycles
//   ST_DONE    | all released, waiting for request
module messbauer_reset_sequencer
  import messbauer_reset_sequencer_pkg::*;
#(
  parameter int CHANNEL_COUNT = 2,
  parameter int PRE_DELAY     = DEFAULT_PRE_DELAY,
  parameter int PULSE_WIDTH   = DEFAULT_PULSE_WIDTH,
  parameter int STAGGER       = 0,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  messbauer_reset_sequencer_if.slave  bus
);

  localparam int IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
  localparam logic [COUNTER_WIDTH-1:0] PRE_LAST = COUNTER_WIDTH'(PRE_DELAY - 1);
  localparam logic [COUNTER_WIDTH-1:0] PW_LAST  = COUNTER_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] STG_LAST = COUNTER_WIDTH'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(CHANNEL_COUNT - 1);
  // Whole mask is released in one go, so RELEASE is skipped entirely.
  localparam bit SINGLE_RELEASE = (STAGGER == 0) || (CHANNEL_COUNT == 1);

  if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > 16 || PRE_DELAY < 1 || PULSE_WIDTH < 1 ||
      STAGGER < 0 || max3(PRE_DELAY, PULSE_WIDTH, STAGGER) > (2 ** COUNTER_WIDTH) - 1)
  begin : g_param_check
    $error("messbauer_reset_sequencer: invalid parameter combination");
  end

  seq_state_t               r_state;
  seq_state_t               w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic [COUNTER_WIDTH-1:0] w_counter_nxt;
  logic [IDX_W-1:0]         r_index;
  logic [IDX_W-1:0]         w_index_nxt;
  logic [IDX_W-1:0]         w_index_inc;
  logic                     r_busy;
  logic                     r_done;
  logic                     w_clear;
  logic                     w_start;
  logic                     w_step;
  logic [CHANNEL_COUNT-1:0] w_mask;

  assign w_index_inc = r_index + IDX_W'(1);

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state   <= ST_WAIT;
      r_counter <= '0;
      r_index   <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
      r_index   <= w_index_nxt;
      r_busy    <= (w_state_nxt != ST_DONE);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter + COUNTER_WIDTH'(1);
    w_index_nxt   = r_index;
    w_clear       = 1'b0;
    w_start       = 1'b0;
    w_step        = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_counter == PRE_LAST) begin
          w_state_nxt   = ST_ASSERT;
          w_counter_nxt = '0;
          w_clear       = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (r_counter == PW_LAST) begin
          w_counter_nxt = '0;
          w_index_nxt   = '0;
          w_start       = 1'b1;
          w_state_nxt   = SINGLE_RELEASE ? ST_DONE : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (r_counter == STG_LAST) begin
          w_counter_nxt = '0;
          w_index_nxt   = w_index_inc;
          w_step        = 1'b1;
          if (w_index_inc == IDX_LAST) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_counter_nxt = r_counter;
        if (bus.request) begin
          w_state_nxt   = ST_WAIT;
          w_counter_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_WAIT;
        w_counter_nxt = '0;
      end
    endcase
  end

  messbauer_reset_sequencer_release_shifter #(
    .CHANNEL_COUNT (CHANNEL_COUNT),
    .STAGGER       (STAGGER)
  ) u_release_shifter (
    .i_clk   (i_aclk),
    .i_rst   (i_areset),
    .i_clear (w_clear),
    .i_start (w_start),
    .i_step  (w_step),
    .o_mask  (w_mask)
  );

  assign bus.channel_reset_n = w_mask;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_messbauer_reset_sequencer.sv
// Bench for three sequencer configurations sharing one clock: defaults, a
// staggered four-channel build and a minimal single-channel build.
module tb_messbauer_reset_sequencer;

  localparam int P_CH  [3] = '{2, 4, 1};
  localparam int P_PRE [3] = '{16, 4, 1};
  localparam int P_PW  [3] = '{16, 8, 1};
  localparam int P_STG [3] = '{0, 3, 2};

  typedef struct {
    int         ph;
    int         cyc;
    logic       rst;
    logic [2:0] req;
    bit         chk;
    int         dut;
    logic [3:0] exp_n;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  typedef struct {
    int         cyc;
    int         dut;
    logic [5:0] exp;
  } sb_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   m_start [3];
  vec_t vecs [$];
  sb_t  sbq [$];

  messbauer_reset_sequencer_if #(.CHANNEL_COUNT(2)) if0 ();
  messbauer_reset_sequencer_if #(.CHANNEL_COUNT(4)) if1 ();
  messbauer_reset_sequencer_if #(.CHANNEL_COUNT(1)) if2 ();

  messbauer_reset_sequencer #(
    .CHANNEL_COUNT(2), .PRE_DELAY(16), .PULSE_WIDTH(16), .STAGGER(0), .COUNTER_WIDTH(8)
  ) u_dut0 (.i_aclk(clk), .i_areset(rst), .bus(if0));

  messbauer_reset_sequencer #(
    .CHANNEL_COUNT(4), .PRE_DELAY(4), .PULSE_WIDTH(8), .STAGGER(3), .COUNTER_WIDTH(8)
  ) u_dut1 (.i_aclk(clk), .i_areset(rst), .bus(if1));

  messbauer_reset_sequencer #(
    .CHANNEL_COUNT(1), .PRE_DELAY(1), .PULSE_WIDTH(1), .STAGGER(2), .COUNTER_WIDTH(4)
  ) u_dut2 (.i_aclk(clk), .i_areset(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] get_act(input int d);
    case (d)
      0:       return {if0.busy, if0.done, 2'b00, if0.channel_reset_n};
      1:       return {if1.busy, if1.done, if1.channel_reset_n};
      default: return {if2.busy, if2.done, 3'b000, if2.channel_reset_n};
    endcase
  endfunction

  function automatic int done_time(input int d);
    return P_PRE[d] + P_PW[d] + (P_CH[d] - 1) * P_STG[d];
  endfunction

  // Closed-form expectation from cycles elapsed since the sequence started.
  function automatic logic [5:0] model_exp(input int d, input int t);
    logic [3:0] all;
    logic [3:0] en;
    int         r;
    all = 4'((1 << P_CH[d]) - 1);
    if (t < P_PRE[d]) return {2'b10, all};
    if (t < P_PRE[d] + P_PW[d]) return 6'b10_0000;
    if (t >= done_time(d)) return {2'b01, all};
    r  = t - P_PRE[d] - P_PW[d];
    en = 4'b0000;
    for (int k = 0; k < P_CH[d]; k++)
      if (k * P_STG[d] <= r) en[k] = 1'b1;
    return {2'b10, en};
  endfunction

  task automatic check(input string nm, input int d, input int n,
                       input logic [5:0] act, input logic [5:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got rst_n=%b busy=%b done=%b, want rst_n=%b busy=%b done=%b",
                  nm, d, n, act[3:0], act[5], act[4], exp[3:0], exp[5], exp[4]);
  endtask

  task automatic push_exp(input int d, input int c);
    sbq.push_back('{cyc: c, dut: d, exp: model_exp(d, c - m_start[d])});
  endtask

  task automatic model_step(input int n, input logic r, input logic [2:0] rq);
    for (int d = 0; d < 3; d++) begin
      if (r) m_start[d] = n + 1;
      else if (rq[d] && (n - m_start[d]) >= done_time(d)) m_start[d] = n + 1;
      push_exp(d, n + 1);
    end
  endtask

  task automatic add_stim(input int ph, input int cyc, input logic r, input logic [2:0] rq);
    vecs.push_back('{ph: ph, cyc: cyc, rst: r, req: rq, chk: 1'b0, dut: 0,
                     exp_n: 4'b0, exp_busy: 1'b0, exp_done: 1'b0});
  endtask

  task automatic add_chk(input int ph, input int cyc, input int d,
                         input logic [3:0] en, input logic b, input logic dn);
    vecs.push_back('{ph: ph, cyc: cyc, rst: 1'b0, req: 3'b000, chk: 1'b1, dut: d,
                     exp_n: en, exp_busy: b, exp_done: dn});
  endtask

  task automatic run_phase(input int ph, input int ncyc);
    logic       r;
    logic [2:0] rq;
    rst = 1'b1;
    if0.request = 1'b0; if1.request = 1'b0; if2.request = 1'b0;
    repeat (3) @(posedge clk);
    sbq.delete();
    for (int d = 0; d < 3; d++) begin
      m_start[d] = 0;
      push_exp(d, 0);
    end
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc == n) begin
        sb_t e;
        e = sbq.pop_front();
        check("model", e.dut, n, get_act(e.dut), e.exp);
      end
      r  = 1'b0;
      rq = 3'b000;
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].ph == ph && vecs[i].cyc == n) begin
          if (vecs[i].chk)
            check("table", vecs[i].dut, n, get_act(vecs[i].dut),
                  {vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_n});
          else begin
            r  = r | vecs[i].rst;
            rq = rq | vecs[i].req;
          end
        end
      end
      rst = r;
      if0.request = rq[0]; if1.request = rq[1]; if2.request = rq[2];
      model_step(n, r, rq);
      @(posedge clk);
    end
    if0.request = 1'b0; if1.request = 1'b0; if2.request = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    if0.request = 1'b0; if1.request = 1'b0; if2.request = 1'b0;

    // Phase 0: power-on sequence, ignored requests, re-trigger at cycle 40.
    add_stim(0, 6,  1'b0, 3'b010);
    add_stim(0, 13, 1'b0, 3'b010);
    add_stim(0, 19, 1'b0, 3'b010);
    add_stim(0, 20, 1'b0, 3'b001);
    add_stim(0, 40, 1'b0, 3'b111);
    add_stim(0, 41, 1'b0, 3'b100);
    add_stim(0, 42, 1'b0, 3'b100);
    add_chk(0, 0,  0, 4'b0011, 1, 0);
    add_chk(0, 15, 0, 4'b0011, 1, 0);
    add_chk(0, 16, 0, 4'b0000, 1, 0);
    add_chk(0, 31, 0, 4'b0000, 1, 0);
    add_chk(0, 32, 0, 4'b0011, 0, 1);
    add_chk(0, 40, 0, 4'b0011, 0, 1);
    add_chk(0, 41, 0, 4'b0011, 1, 0);
    add_chk(0, 56, 0, 4'b0011, 1, 0);
    add_chk(0, 57, 0, 4'b0000, 1, 0);
    add_chk(0, 72, 0, 4'b0000, 1, 0);
    add_chk(0, 73, 0, 4'b0011, 0, 1);
    add_chk(0, 3,  1, 4'b1111, 1, 0);
    add_chk(0, 4,  1, 4'b0000, 1, 0);
    add_chk(0, 11, 1, 4'b0000, 1, 0);
    add_chk(0, 12, 1, 4'b0001, 1, 0);
    add_chk(0, 14, 1, 4'b0001, 1, 0);
    add_chk(0, 15, 1, 4'b0011, 1, 0);
    add_chk(0, 18, 1, 4'b0111, 1, 0);
    add_chk(0, 20, 1, 4'b0111, 1, 0);
    add_chk(0, 21, 1, 4'b1111, 0, 1);
    add_chk(0, 41, 1, 4'b1111, 1, 0);
    add_chk(0, 45, 1, 4'b0000, 1, 0);
    add_chk(0, 53, 1, 4'b0001, 1, 0);
    add_chk(0, 62, 1, 4'b1111, 0, 1);
    add_chk(0, 0,  2, 4'b0001, 1, 0);
    add_chk(0, 1,  2, 4'b0000, 1, 0);
    add_chk(0, 2,  2, 4'b0001, 0, 1);
    add_chk(0, 41, 2, 4'b0001, 1, 0);
    add_chk(0, 42, 2, 4'b0000, 1, 0);
    add_chk(0, 43, 2, 4'b0001, 0, 1);

    // Phase 1: areset pulsed mid-sequence for three cycles.
    add_stim(1, 5,  1'b0, 3'b100);
    add_stim(1, 20, 1'b1, 3'b000);
    add_stim(1, 21, 1'b1, 3'b000);
    add_stim(1, 22, 1'b1, 3'b000);
    add_chk(1, 20, 0, 4'b0000, 1, 0);
    add_chk(1, 21, 0, 4'b0011, 1, 0);
    add_chk(1, 23, 0, 4'b0011, 1, 0);
    add_chk(1, 38, 0, 4'b0011, 1, 0);
    add_chk(1, 39, 0, 4'b0000, 1, 0);
    add_chk(1, 54, 0, 4'b0000, 1, 0);
    add_chk(1, 55, 0, 4'b0011, 0, 1);
    add_chk(1, 20, 1, 4'b0111, 1, 0);
    add_chk(1, 21, 1, 4'b1111, 1, 0);
    add_chk(1, 35, 1, 4'b0001, 1, 0);
    add_chk(1, 44, 1, 4'b1111, 0, 1);
    add_chk(1, 6,  2, 4'b0001, 1, 0);
    add_chk(1, 7,  2, 4'b0000, 1, 0);
    add_chk(1, 8,  2, 4'b0001, 0, 1);

    run_phase(0, 80);
    run_phase(1, 60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
